// File: rtl/axi_fetch_if.sv
// Read-address/read-data channels of an AXI4 master plus the AXI4-Stream
// output of the frame fetcher, grouped so the fetcher and its peers share one bundle.
interface axi_fetch_if #(
    parameter int ID_WIDTH   = 8,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
);
    logic [ID_WIDTH-1:0]   m_axi_arid;
    logic [ADDR_WIDTH-1:0] m_axi_araddr;
    logic [7:0]            m_axi_arlen;
    logic [2:0]            m_axi_arsize;
    logic [1:0]            m_axi_arburst;
    logic                  m_axi_arlock;
    logic [3:0]            m_axi_arcache;
    logic [2:0]            m_axi_arprot;
    logic                  m_axi_arvalid;
    logic                  m_axi_arready;
    logic [ID_WIDTH-1:0]   m_axi_rid;
    logic [DATA_WIDTH-1:0] m_axi_rdata;
    logic [1:0]            m_axi_rresp;
    logic                  m_axi_rlast;
    logic                  m_axi_rvalid;
    logic                  m_axi_rready;
    logic [DATA_WIDTH-1:0] m_axis_tdata;
    logic                  m_axis_tvalid;
    logic                  m_axis_tready;
    logic                  m_axis_tlast;

    modport master (
        output m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
               m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arvalid, m_axi_rready,
               m_axis_tdata, m_axis_tvalid, m_axis_tlast,
        input  m_axi_arready, m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast,
               m_axi_rvalid, m_axis_tready
    );

    modport slave (
        input  m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
               m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arvalid, m_axi_rready,
               m_axis_tdata, m_axis_tvalid, m_axis_tlast,
        output m_axi_arready, m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast,
               m_axi_rvalid, m_axis_tready
    );
endinterface

// File: rtl/axi_fetch.sv
// AXI4 read master: fetches one frame in fixed-length INCR bursts and streams
// it out through a small FIFO, marking the final frame word with tlast.
module axi_fetch #(
    parameter int          ID_WIDTH    = 8,
    parameter int          ADDR_WIDTH  = 16,
    parameter int          DATA_WIDTH  = 32,
    parameter int unsigned BASE_ADDR   = 0,
    parameter int          BURST_LEN   = 16,
    parameter int          TOTAL_WORDS = 1024,
    parameter int          FIFO_DEPTH  = 32
) (
    input logic         m_axi_aclk,
    input logic         m_axi_aresetn,
    input logic         start,
    axi_fetch_if.master bus
);
    localparam int NUM_BURSTS = TOTAL_WORDS / BURST_LEN;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int CNT_W      = PTR_W + 1;
    localparam int BL_W       = $clog2(NUM_BURSTS + 1);
    localparam int WC_W       = $clog2(TOTAL_WORDS + 1);

    localparam logic [CNT_W-1:0]      ROOM_LIMIT  = CNT_W'(FIFO_DEPTH - BURST_LEN);
    localparam logic [ADDR_WIDTH-1:0] BURST_BYTES = ADDR_WIDTH'(BURST_LEN * 4);
    localparam logic [ADDR_WIDTH-1:0] BASE        = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [WC_W-1:0]       LAST_WORD   = WC_W'(TOTAL_WORDS - 1);
    localparam logic [BL_W-1:0]       ALL_BURSTS  = BL_W'(NUM_BURSTS);

    typedef enum logic [2:0] {IDLE, ADDR, DATA, DRAIN, DONE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] araddr_q;
    logic [BL_W-1:0]       bursts_left;
    logic [WC_W-1:0]       word_cnt;
    logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      fifo_cnt;
    logic                  ar_valid, r_ready, push, pop, last_beat, t_valid;
    logic                  unused_inputs;

    assign unused_inputs = ^{bus.m_axi_rid, bus.m_axi_rresp};

    assign push      = bus.m_axi_rvalid && r_ready;
    assign pop       = t_valid && bus.m_axis_tready;
    assign last_beat = push && bus.m_axi_rlast;
    assign t_valid   = (fifo_cnt != '0);

    // ADDR never receives data, so free space only grows while arvalid waits for arready
    always_comb begin
        state_d  = state_q;
        ar_valid = 1'b0;
        r_ready  = 1'b0;
        case (state_q)
            IDLE:  if (start) state_d = ADDR;
            ADDR: begin
                ar_valid = (fifo_cnt <= ROOM_LIMIT);
                if (ar_valid && bus.m_axi_arready) state_d = DATA;
            end
            DATA: begin
                r_ready = 1'b1;
                if (bus.m_axi_rvalid && bus.m_axi_rlast)
                    state_d = (bursts_left > BL_W'(1)) ? ADDR : DRAIN;
            end
            DRAIN: if (fifo_cnt == '0) state_d = DONE;
            DONE:  if (!start) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            state_q     <= IDLE;
            araddr_q    <= BASE;
            bursts_left <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_cnt    <= '0;
            word_cnt    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && start) begin
                araddr_q    <= BASE;
                bursts_left <= ALL_BURSTS;
            end else if (last_beat) begin
                araddr_q    <= araddr_q + BURST_BYTES;
                bursts_left <= bursts_left - BL_W'(1);
            end
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            fifo_cnt <= fifo_cnt + CNT_W'(push) - CNT_W'(pop);
            // Output word index wraps to zero on the last word, ending the frame
            if (pop) word_cnt <= (word_cnt == LAST_WORD) ? '0 : word_cnt + WC_W'(1);
        end
    end

    always_ff @(posedge m_axi_aclk) begin
        if (push) fifo_mem[wr_ptr] <= bus.m_axi_rdata;
    end

    assign bus.m_axi_arid    = '0;
    assign bus.m_axi_araddr  = araddr_q;
    assign bus.m_axi_arlen   = 8'(BURST_LEN - 1);
    assign bus.m_axi_arsize  = 3'b010;
    assign bus.m_axi_arburst = 2'b01;
    assign bus.m_axi_arlock  = 1'b0;
    assign bus.m_axi_arcache = 4'b0011;
    assign bus.m_axi_arprot  = 3'b000;
    assign bus.m_axi_arvalid = ar_valid;
    assign bus.m_axi_rready  = r_ready;
    assign bus.m_axis_tvalid = t_valid;
    assign bus.m_axis_tdata  = t_valid ? fifo_mem[rd_ptr] : '0;
    assign bus.m_axis_tlast  = t_valid && (word_cnt == LAST_WORD);
endmodule

// File: tb/tb_axi_fetch.sv
// Bench for axi_fetch: randomized AXI slave and stream sink, with a queue-free
// word-index model of the frame checked every cycle.
`timescale 1ns/1ps
module tb_axi_fetch;
    localparam int BL    = 16;
    localparam int TW    = 1024;
    localparam int NB    = TW / BL;
    localparam int DEPTH = 32;

    logic clk = 1'b0;
    logic aresetn = 1'b0;
    logic start = 1'b0;
    always #5 clk = ~clk;

    axi_fetch_if #(.ID_WIDTH(8), .ADDR_WIDTH(16), .DATA_WIDTH(32)) bus();

    axi_fetch #(
        .ID_WIDTH(8), .ADDR_WIDTH(16), .DATA_WIDTH(32), .BASE_ADDR(0),
        .BURST_LEN(BL), .TOTAL_WORDS(TW), .FIFO_DEPTH(DEPTH)
    ) dut (
        .m_axi_aclk(clk),
        .m_axi_aresetn(aresetn),
        .start(start),
        .bus(bus)
    );

    int tests = 0;
    int fails = 0;
    int tr_mode = 1;
    int gap_pct = 0;
    int ar_delay = 0;
    int frames_done = 0;
    int ar_count = 0;
    int occ = 0;
    int max_occ = 0;
    int exp_idx = 0;
    int beats_total = 0;
    int tlast_seen = 0;
    logic busy = 1'b0;
    logic [15:0] first_addr [3];
    logic [15:0] restart_addr = 16'hFFFF;
    logic [31:0] tlast_data = '0;

    function automatic logic [31:0] mem_word(input int idx);
        return 32'(idx);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_arvalid"}, 64'(bus.m_axi_arvalid), 0);
        check({tag, "_rready"},  64'(bus.m_axi_rready), 0);
        check({tag, "_tvalid"},  64'(bus.m_axis_tvalid), 0);
        check({tag, "_tlast"},   64'(bus.m_axis_tlast), 0);
        check({tag, "_araddr"},  64'(bus.m_axi_araddr), 0);
        check({tag, "_tdata"},   64'(bus.m_axis_tdata), 0);
    endtask

    task automatic wait_frames(input int n, input int budget);
        int k = 0;
        while (frames_done < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("frame_done_in_budget", 64'(frames_done >= n), 1);
    endtask

    // Stream sink: tready pattern chosen by the main sequence
    initial begin : sink
        bus.m_axis_tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (tr_mode)
                0:       bus.m_axis_tready = 1'b0;
                1:       bus.m_axis_tready = 1'b1;
                default: bus.m_axis_tready = ($urandom_range(99) < 60);
            endcase
        end
    end

    // AXI read slave: memory word i holds mem_word(i); one burst served at a time
    initial begin : slave
        int beat, base_word, wait_cnt;
        logic ar_hs, r_hs, arv;
        logic [15:0] addr_s;
        beat = 0; base_word = 0; wait_cnt = 0;
        bus.m_axi_arready = 1'b0;
        bus.m_axi_rvalid  = 1'b0;
        bus.m_axi_rdata   = '0;
        bus.m_axi_rlast   = 1'b0;
        bus.m_axi_rid     = '0;
        bus.m_axi_rresp   = '0;
        forever begin
            @(negedge clk);
            ar_hs  = bus.m_axi_arvalid && bus.m_axi_arready;
            r_hs   = bus.m_axi_rvalid && bus.m_axi_rready;
            arv    = bus.m_axi_arvalid;
            addr_s = bus.m_axi_araddr;
            @(posedge clk);
            #1;
            if (!aresetn) begin
                busy = 1'b0; beat = 0; wait_cnt = 0;
                bus.m_axi_arready = 1'b0;
                bus.m_axi_rvalid  = 1'b0;
                bus.m_axi_rlast   = 1'b0;
            end else begin
                if (r_hs) begin
                    beat++;
                    if (beat == BL) busy = 1'b0;
                end
                if (ar_hs) begin
                    busy = 1'b1; beat = 0; wait_cnt = 0;
                    base_word = int'(addr_s) >> 2;
                    bus.m_axi_arready = 1'b0;
                end else if (arv && !busy) begin
                    wait_cnt++;
                    bus.m_axi_arready = (wait_cnt > ar_delay);
                end else begin
                    bus.m_axi_arready = 1'b0;
                end
                if (busy) begin
                    if (!(bus.m_axi_rvalid && !r_hs))
                        bus.m_axi_rvalid = ($urandom_range(99) >= gap_pct);
                    bus.m_axi_rdata = mem_word(base_word + beat);
                    bus.m_axi_rlast = (beat == BL - 1);
                    bus.m_axi_rid   = 8'($urandom);
                    bus.m_axi_rresp = 2'($urandom);
                end else begin
                    bus.m_axi_rvalid = 1'b0;
                    bus.m_axi_rlast  = 1'b0;
                end
            end
        end
    end

    // Compare process: frame position, FIFO occupancy and AR rules checked every cycle
    initial begin : monitor
        logic prev_tstall, prev_arstall;
        logic [31:0] prev_tdata;
        logic [15:0] prev_araddr;
        prev_tstall = 1'b0; prev_arstall = 1'b0; prev_tdata = '0; prev_araddr = '0;
        forever begin
            @(negedge clk);
            if (!aresetn) begin
                occ = 0; exp_idx = 0; ar_count = 0; beats_total = 0; max_occ = 0;
                prev_tstall = 1'b0; prev_arstall = 1'b0;
            end else begin
                check("tvalid_vs_occ", 64'(bus.m_axis_tvalid), 64'(occ != 0));
                if (bus.m_axis_tvalid) begin
                    check("tdata", 64'(bus.m_axis_tdata), 64'(mem_word(exp_idx)));
                    check("tlast", 64'(bus.m_axis_tlast), 64'(exp_idx == TW - 1));
                end else begin
                    check("tlast_idle", 64'(bus.m_axis_tlast), 0);
                end
                if (prev_tstall) check("tdata_hold", 64'(bus.m_axis_tdata), 64'(prev_tdata));
                if (bus.m_axi_arvalid) begin
                    check("ar_room", 64'((DEPTH - occ) >= BL), 1);
                    check("ar_one_outstanding", 64'(busy), 0);
                    check("arlen", 64'(bus.m_axi_arlen), 15);
                end
                if (prev_arstall) begin
                    check("arvalid_hold", 64'(bus.m_axi_arvalid), 1);
                    check("araddr_hold", 64'(bus.m_axi_araddr), 64'(prev_araddr));
                end
                if (bus.m_axi_arvalid && bus.m_axi_arready) begin
                    check("araddr", 64'(bus.m_axi_araddr), 64'((ar_count % NB) * BL * 4));
                    if (frames_done == 0 && ar_count < 3) first_addr[ar_count] = bus.m_axi_araddr;
                    if (ar_count == 0) restart_addr = bus.m_axi_araddr;
                    ar_count++;
                end
                if (bus.m_axi_rvalid && bus.m_axi_rready) begin
                    occ++;
                    beats_total++;
                end
                if (bus.m_axis_tvalid && bus.m_axis_tready) begin
                    if (bus.m_axis_tlast) begin
                        tlast_seen++;
                        tlast_data = bus.m_axis_tdata;
                    end
                    occ--;
                    exp_idx++;
                    if (exp_idx == TW) begin
                        exp_idx = 0;
                        frames_done++;
                    end
                end
                if (occ > max_occ) max_occ = occ;
                prev_tstall  = bus.m_axis_tvalid && !bus.m_axis_tready;
                prev_tdata   = bus.m_axis_tdata;
                prev_arstall = bus.m_axi_arvalid && !bus.m_axi_arready;
                prev_araddr  = bus.m_axi_araddr;
            end
        end
    end

    initial begin : main
        int quiet_viol;
        int k;
        repeat (5) @(negedge clk);
        check_reset_outputs("reset");
        check("arid",    64'(bus.m_axi_arid), 0);
        check("arsize",  64'(bus.m_axi_arsize), 2);
        check("arburst", 64'(bus.m_axi_arburst), 1);
        check("arcache", 64'(bus.m_axi_arcache), 3);
        check("arlock",  64'(bus.m_axi_arlock), 0);
        check("arprot",  64'(bus.m_axi_arprot), 0);
        #2 aresetn = 1'b1;

        // Basic frame, full-rate sink
        @(negedge clk);
        start = 1'b1;
        wait_frames(1, 6000);
        check("first_addr0", 64'(first_addr[0]), 64'h0000);
        check("first_addr1", 64'(first_addr[1]), 64'h0040);
        check("first_addr2", 64'(first_addr[2]), 64'h0080);
        check("tlast_count_f1", 64'(tlast_seen), 1);
        check("tlast_word_f1", 64'(tlast_data), 64'd1023);
        quiet_viol = 0;
        repeat (200) begin
            @(negedge clk);
            if (bus.m_axi_arvalid || bus.m_axis_tvalid) quiet_viol++;
        end
        check("no_second_frame", 64'(quiet_viol), 0);

        // Re-arm with slow arready, rvalid gaps and random tready
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        ar_delay = 6; gap_pct = 30; tr_mode = 2;
        wait_frames(2, 20000);
        check("tlast_count_f2", 64'(tlast_seen), 2);
        check("tlast_word_f2", 64'(tlast_data), 64'd1023);

        // Back-pressure from reset
        repeat (5) @(negedge clk);
        start = 1'b0; tr_mode = 0; ar_delay = 0; gap_pct = 0;
        #2 aresetn = 1'b0;
        repeat (5) @(negedge clk);
        #2 aresetn = 1'b1;
        @(negedge clk);
        start = 1'b1;
        repeat (60) @(negedge clk);
        check("bp_words_fetched", 64'(beats_total), 64'(DEPTH));
        check("bp_max_occ", 64'(max_occ <= DEPTH), 1);
        tr_mode = 1;
        repeat (2) @(negedge clk);
        tr_mode = 0;
        repeat (2) @(negedge clk);
        tr_mode = 1;
        wait_frames(3, 8000);
        check("tlast_count_f3", 64'(tlast_seen), 3);

        // Reset during burst 3, then restart from word 0
        repeat (5) @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; gap_pct = 20; tr_mode = 2;
        k = 0;
        while (ar_count < 3 && k < 2000) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("reached_burst3", 64'(ar_count >= 3), 1);
        repeat (4) @(negedge clk);
        #2 aresetn = 1'b0;
        #1 check_reset_outputs("midreset");
        restart_addr = 16'hFFFF;
        repeat (3) @(negedge clk);
        #2 aresetn = 1'b1;
        wait_frames(4, 20000);
        check("restart_addr", 64'(restart_addr), 64'h0000);
        check("tlast_count_f4", 64'(tlast_seen), 4);
        check("tlast_word_f4", 64'(tlast_data), 64'd1023);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/axi_fetch.md
Name: axi_fetch

Overview:
AXI4 read master that fetches one frame of 32-bit words from memory and emits it as an AXI4-Stream.
- On `start` it issues fixed-length INCR read bursts from BASE_ADDR.
- Returned data is buffered in a small FIFO and streamed out, with `tlast` on the final word of the frame.
- Sits between the system AXI interconnect or memory and downstream pixel-processing stream logic.

Parameters:
ID_WIDTH 8 AXI ID width
ADDR_WIDTH 16 AXI address width (byte address)
DATA_WIDTH 32 AXI data width; the stream is also 32 bits; only 32 is supported
BASE_ADDR 0 byte address of word 0 of the frame; must be aligned to BURST_LEN*4
BURST_LEN 16 beats per burst (1..256)
TOTAL_WORDS 1024 words per frame; must be a multiple of BURST_LEN
FIFO_DEPTH 32 output FIFO depth in words; power of two, >= BURST_LEN

Ports:
m_axi_aclk in 1 clock
m_axi_aresetn in 1 asynchronous active-low reset
start in 1 level; high in IDLE begins a frame
m_axi_arid out ID_WIDTH constant 0
m_axi_araddr out ADDR_WIDTH burst start byte address
m_axi_arlen out 8 constant BURST_LEN-1
m_axi_arsize out 3 constant 3'b010 (4 bytes)
m_axi_arburst out 2 constant 2'b01 (INCR)
m_axi_arlock out 1 constant 0
m_axi_arcache out 4 constant 4'b0011
m_axi_arprot out 3 constant 0
m_axi_arvalid out 1 address valid
m_axi_arready in 1 address ready
m_axi_rid in ID_WIDTH ignored
m_axi_rdata in DATA_WIDTH read data
m_axi_rresp in 2 ignored; data is forwarded regardless
m_axi_rlast in 1 last beat of burst
m_axi_rvalid in 1 read data valid
m_axi_rready out 1 read data ready
m_axis_tdata out 32 stream data
m_axis_tvalid out 1 stream valid
m_axis_tready in 1 stream ready
m_axis_tlast out 1 final word of frame

Behaviour:
- **Reset:** asynchronous assertion while aresetn=0. Resets:
  - all outputs: arvalid=0, rready=0, tvalid=0, tlast=0, araddr=BASE_ADDR, tdata=0
  - FIFO emptied, all counters 0, FSM in IDLE.
- **Reset mid-operation:** aborts the frame and discards FIFO contents. Nothing is retained after reset.
- **FSM states:** IDLE, ADDR, DATA, DRAIN, DONE.
- **IDLE:** if start=1, load araddr=BASE_ADDR and bursts_left=TOTAL_WORDS/BURST_LEN, then go to ADDR.
- **ADDR:**
  - Assert arvalid only when FIFO free space >= BURST_LEN (free space counts entries not yet written).
  - Once asserted, arvalid and araddr hold stable until arready.
  - On arvalid&arready go to DATA.
- **DATA:**
  - rready=1 in DATA; FIFO space is guaranteed by the ADDR check.
  - Each rvalid&rready beat writes rdata into the FIFO.
  - On a beat with rlast=1: araddr += BURST_LEN*4 and bursts_left decrements. Go to ADDR if bursts_left was >1, else go to DRAIN.
  - Only one burst is outstanding at a time.
- **DRAIN:** wait until the FIFO is empty and the last word has been accepted, then go to DONE.
- **DONE:** wait for start=0, then return to IDLE. Holding start high therefore produces exactly one frame.
- **Stream side:**
  - tvalid=1 whenever the FIFO is non-empty; tdata is the FIFO head word.
  - The head word pops on tvalid&tready.
  - tdata and tvalid hold stable while tvalid=1 and tready=0.
  - Write-to-tvalid latency is 1 cycle (registered FIFO).
  - Simultaneous FIFO push and pop in one cycle is supported.
- **tlast:** an output word counter (0..TOTAL_WORDS-1) increments per accepted word. tlast=1 exactly when tvalid=1 and counter=TOTAL_WORDS-1. The counter clears at frame end.
- **Ordering:** words are emitted in address order with no loss or duplication under any tready pattern.
- **Address arithmetic:** modulo 2^ADDR_WIDTH. BASE_ADDR alignment guarantees no burst crosses a 4 KB boundary.

Test Plan:
- **Basic frame:** reset 5 cycles, start=1, memory word i = i, tready=1 → AR bursts at addr 0x0000, 0x0040, ... with arlen=15, arsize=2, arburst=1. Stream emits 0..1023 in order; tlast only on word 1023; no second frame while start stays high.
- **Back-pressure:** tready=0 for 50 cycles after reset, then 1 for 2 cycles, 0 for 2 cycles, then 1 → at most FIFO_DEPTH words are fetched before first consumption; arvalid is never asserted with free space <16; output is still 0,1,2,... with no gaps or repeats; tdata is stable during stalls.
- **arready delay:** slave holds arready=0 for 7 cycles → arvalid and araddr stay stable; the burst proceeds normally afterward.
- **rvalid gaps:** slave inserts idle cycles between beats → data intact; next AR is issued only after rlast.
- **Reset mid-burst:** assert aresetn=0 during burst 3 → all outputs go to reset values immediately. After release with start=1, the frame restarts at BASE_ADDR, beginning with word 0.
- **Re-arm:** after DONE, drop start for 1 cycle, then raise it → a second identical frame is fetched with tlast on its word 1023.
